// File: rtl/wr_buffer_pkg.sv
// Shared constants for the wrapper output buffer: beat width, drop counter
// width and a constant-foldable log2 helper for sizing pointers.
package wr_buffer_pkg;

  localparam int DATA_W     = 21;
  localparam int DROP_CNT_W = 8;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/wr_buffer_mem.sv
// DEPTH x DATA_W register array: synchronous write, asynchronous read by address.
module wr_buffer_mem #(
  parameter int DATA_W = 21,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: storage is deliberately not reset; validity is tracked by the
  // pointers and occupancy count, so stale contents are never presented.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/wr_buffer.sv
// Show-ahead FIFO absorbing wrapper write beats, with a valid/ready read side
// and a sticky overflow flag plus saturating count of beats lost while full.
module wr_buffer #(
  parameter int DATA_W = wr_buffer_pkg::DATA_W,
  parameter int DEPTH  = 8,
  parameter int AW     = wr_buffer_pkg::clog2(DEPTH)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_req,
  input  logic [DATA_W-1:0]                   wr_data,
  input  logic                                rd_ready,
  output logic                                rd_valid,
  output logic [DATA_W-1:0]                   rd_data,
  output logic [AW:0]                         count,
  output logic                                full,
  output logic                                empty,
  output logic                                overflow,
  output logic [wr_buffer_pkg::DROP_CNT_W-1:0] drop_cnt,
  input  logic                                ovf_clr
);

  import wr_buffer_pkg::*;

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [AW-1:0]         wp_q, wp_d;
  logic [AW-1:0]         rp_q, rp_d;
  logic [AW:0]           count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic                  push, pop, drop;
  logic [DATA_W-1:0]     mem_rdata;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // A pop frees the head slot in the same cycle, so a full buffer still accepts.
  assign pop  = !empty && rd_ready;
  assign push = wr_req && (!full || pop);
  assign drop = wr_req && full && !pop;

  always_comb begin
    // NOTE: every next-state signal is defaulted to its current value first,
    // so no branch can leave one unassigned and infer a latch.
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;

    if (push) wp_d = wp_q + 1'b1;
    if (pop)  rp_d = rp_q + 1'b1;

    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    if (ovf_clr) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end

    // A drop in the same cycle as a clear restarts the tally at one.
    if (drop) begin
      ovf_d = 1'b1;
      if (ovf_clr) begin
        drop_d = DROP_CNT_W'(1);
      end else if (drop_q != '1) begin
        drop_d = drop_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  wr_buffer_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wp_q),
    .wdata_i (wr_data),
    .raddr_i (rp_q),
    .rdata_o (mem_rdata)
  );

  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem_rdata;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_wr_buffer.sv
// Self-checking bench for wr_buffer: directed scenarios plus random traffic,
// every cycle compared against a queue-based model of the buffer.
module tb_wr_buffer;

  localparam int DATA_W = 21;
  localparam int DEPTH  = 8;
  localparam int AW     = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_req;
  logic [DATA_W-1:0] wr_data;
  logic              rd_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [AW:0]       count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic [7:0]        drop_cnt;
  logic              ovf_clr;

  int checks = 0;
  int errors = 0;

  // Reference model: queue contents, sticky flag and drop tally.
  logic [DATA_W-1:0] mq[$];
  bit                m_ovf;
  int                m_drop;
  bit                model_ok = 1'b0;

  always #5 clk = ~clk;

  wr_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_req   (wr_req),
    .wr_data  (wr_data),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .drop_cnt (drop_cnt),
    .ovf_clr  (ovf_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_model();
    int n;
    n = mq.size();
    check("rd_valid", 32'(rd_valid), 32'(n != 0));
    check("rd_data",  32'(rd_data),  (n != 0) ? 32'(mq[0]) : 32'd0);
    check("count",    32'(count),    32'(n));
    check("full",     32'(full),     32'(n == DEPTH));
    check("empty",    32'(empty),    32'(n == 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic model_update(input bit w, input logic [DATA_W-1:0] d,
                              input bit r, input bit c, input bit rs);
    bit was_full, do_pop;
    if (rs) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
      return;
    end
    was_full = (mq.size() == DEPTH);
    do_pop   = (mq.size() != 0) && r;
    if (c) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    if (do_pop) void'(mq.pop_front());
    if (w) begin
      if (!was_full || do_pop) begin
        mq.push_back(d);
      end else begin
        m_ovf  = 1'b1;
        m_drop = c ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
      end
    end
  endtask

  // Called at a falling edge: compare, drive, take the rising edge, advance model.
  task automatic step(input bit w, input logic [DATA_W-1:0] d,
                      input bit r, input bit c, input bit rs);
    if (model_ok) compare_model();
    wr_req   = w;
    wr_data  = d;
    rd_ready = r;
    ovf_clr  = c;
    rst      = rs;
    @(posedge clk);
    model_update(w, d, r, c, rs);
    if (rs) model_ok = 1'b1;
    @(negedge clk);
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_one();
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [DATA_W-1:0] last;
    rst = 1'b1; wr_req = 1'b0; wr_data = '0; rd_ready = 1'b0; ovf_clr = 1'b0;
    @(negedge clk);

    // Reset held for two cycles, then a single beat.
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("rst_empty",    32'(empty),    32'd1);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data",  32'(rd_data),  32'd0);
    check("rst_count",    32'(count),    32'd0);
    push(21'h1ABCDE);
    check("single_valid", 32'(rd_valid), 32'd1);
    check("single_data",  32'(rd_data),  32'h1ABCDE);
    check("single_count", 32'(count),    32'd1);
    pop_one();

    // Fill, drop a ninth beat, then drain in order.
    for (int i = 1; i <= DEPTH; i++) push(DATA_W'(i));
    check("fill_full", 32'(full), 32'd1);
    push(DATA_W'(9));
    check("drop_ovf", 32'(overflow), 32'd1);
    check("drop_cnt1", 32'(drop_cnt), 32'd1);
    for (int i = 1; i <= DEPTH; i++) begin
      check("drain_order", 32'(rd_data), 32'(i));
      pop_one();
    end
    check("drain_empty", 32'(empty), 32'd1);

    // Simultaneous push and pop while full.
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) push(DATA_W'(32'h300 + i));
    step(1'b1, 21'h0000AA, 1'b1, 1'b0, 1'b0);
    check("full_pp_count", 32'(count),    32'd8);
    check("full_pp_ovf",   32'(overflow), 32'd0);
    last = '0;
    for (int i = 0; i < DEPTH; i++) begin
      last = rd_data;
      pop_one();
    end
    check("full_pp_last", 32'(last), 32'h0000AA);

    // Wrap-around: interleaved push/pop of an incrementing pattern.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, DATA_W'(32'h500 + i), (i % 3) != 0, 1'b0, 1'b0);
      check("wrap_cnt_le8", 32'(count <= 4'd8), 32'd1);
    end
    for (int i = 0; i < DEPTH + 2; i++) pop_one();
    check("wrap_drained", 32'(empty), 32'd1);

    // Saturation, clear, and clear coincident with a drop.
    for (int i = 0; i < DEPTH; i++) push(DATA_W'(32'h700 + i));
    for (int i = 0; i < 300; i++) push(DATA_W'($urandom));
    check("sat_cnt", 32'(drop_cnt), 32'd255);
    check("sat_ovf", 32'(overflow), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_cnt", 32'(drop_cnt), 32'd0);
    step(1'b1, 21'h1F00F, 1'b0, 1'b1, 1'b0);
    check("clr_drop_ovf", 32'(overflow), 32'd1);
    check("clr_drop_cnt", 32'(drop_cnt), 32'd1);

    // Reset mid-operation with a write in the same cycle.
    for (int i = 0; i < 3; i++) pop_one();
    check("mid_count5", 32'(count), 32'd5);
    step(1'b1, 21'h0BEEF, 1'b0, 1'b0, 1'b1);
    check("mid_rst_count", 32'(count),    32'd0);
    check("mid_rst_empty", 32'(empty),    32'd1);
    check("mid_rst_ovf",   32'(overflow), 32'd0);
    push(21'h155555);
    check("post_rst_data", 32'(rd_data), 32'h155555);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) < 6, DATA_W'($urandom), $urandom_range(0, 9) < 5,
           $urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0);
    end
    compare_model();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
